// File: rtl/mbgd_pkg.sv
// Shared constants and helpers for the MBGD error stage.
// Lane mode encoding, ceil-log2 and a width-generic signed clamp.
package mbgd_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Clamp a sign-extended value into the signed range of w bits.
  function automatic logic [63:0] sat_clamp(
    input logic signed [63:0] d,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

endpackage

// File: rtl/mbgd_lane_sub.sv
// One lane of the error stage: e = a - b, wrapped or saturated.
// Purely combinational; the top registers the result.
module mbgd_lane_sub
  import mbgd_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sat_en,
  output logic [DW-1:0] e
);

  logic signed [DW:0] d;
  logic [63:0]        c;
  logic               unused_hi;

  assign d = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
  assign c = sat_clamp(64'(d), DW);

  assign unused_hi = ^c[63:DW];

  assign e = (sat_en == MODE_SAT) ? c[DW-1:0] : d[DW-1:0];

endmodule

// File: rtl/mbgd_hy_error_stage.sv
// MBGD error stage: per-lane h - y behind a valid/ready register
// slice, with a running signed error sum over each mini-batch.
module mbgd_hy_error_stage
  import mbgd_pkg::*;
#(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int BATCH = 4,
  parameter int ACC_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              sat_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW*N-1:0]   inp1,
  input  logic [DW*N-1:0]   inp2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW*N-1:0]   diff,
  output logic [ACC_W-1:0]  batch_sum,
  output logic              batch_last
);

  localparam int CW = (clog2(BATCH) < 1) ? 1 : clog2(BATCH);
  localparam logic [CW-1:0] LAST_CNT = CW'(BATCH - 1);

  generate
    if (ACC_W < DW + clog2(N) + clog2(BATCH)) begin : g_acc_chk
      $error("ACC_W too narrow for a full batch of lane errors");
    end
  endgenerate

  logic [N-1:0][DW-1:0] err;
  logic [ACC_W-1:0]     vsum;
  logic                 accept;

  logic                 valid_q, valid_d;
  logic [DW*N-1:0]      diff_q, diff_d;
  logic [ACC_W-1:0]     sum_q, sum_d;
  logic                 last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    mbgd_lane_sub #(
      .DW(DW)
    ) u_lane (
      .a     (inp1[gi*DW +: DW]),
      .b     (inp2[gi*DW +: DW]),
      .sat_en(sat_en),
      .e     (err[gi])
    );
  end

  always_comb begin
    vsum = '0;
    for (int i = 0; i < N; i++) begin
      vsum = vsum + ACC_W'($signed(err[i]));
    end
  end

  assign in_ready = !clear && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    diff_d  = diff_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (clear) begin
      valid_d = 1'b0;
      sum_d   = '0;
      last_d  = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      diff_d  = err;
      sum_d   = (cnt_q == '0) ? vsum : sum_q + vsum;
      last_d  = (cnt_q == LAST_CNT);
      cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      diff_q  <= '0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      diff_q  <= diff_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign diff       = diff_q;
  assign batch_sum  = sum_q;
  assign batch_last = last_q;

endmodule
